// File: rtl/run_counter_pkg.sv
// Shared constants for the run_counter slice: sequencer state codes,
// default sizing and a parameter legality helper.
package run_counter_pkg;

   localparam int     WIDTH_DEF    = 6;
   localparam longint TERMINAL_DEF = 32;

   // Sequencer state codes (kept numerically identical to the legacy defines)
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // TERMINAL must lie in 1..2**WIDTH; evaluated in 64 bits so WIDTH=32 is safe
   function automatic bit terminal_ok(input int width, input longint term);
      return (term >= 1) && (term <= (longint'(1) << width));
   endfunction

endpackage

// File: rtl/run_counter_core.sv
// Count register with clear/load/increment/decrement, wrap or saturate at
// the range ends, terminal flag and a one-edge wrap/saturation event.
module counter_core
   import run_counter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clock,
   input  logic             clr_n,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             inc,
   input  logic             dec,
   input  logic             sat,
   input  logic             up_dn,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             evt
);

   logic [WIDTH-1:0] nxt;
   logic             at_max;
   logic             at_min;

   assign at_max = (count == '1);
   assign at_min = (count == '0);
   assign tc     = up_dn ? at_max : at_min;

   // Next count: clear beats load beats stepping; ends of range wrap or hold
   always_comb begin
      nxt = count;
      evt = 1'b0;
      if (clr) begin
         nxt = '0;
      end else if (load) begin
         nxt = load_val;
      end else if (inc) begin
         evt = at_max;
         nxt = (at_max && sat) ? count : count + WIDTH'(1);
      end else if (dec) begin
         evt = at_min;
         nxt = (at_min && sat) ? count : count - WIDTH'(1);
      end
   end

   // Count register
   always_ff @(posedge clock or negedge clr_n) begin
      if (!clr_n) count <= '0;
      else        count <= nxt;
   end

endmodule

// File: rtl/run_counter.sv
// Up/down counter with load and a start/busy/done run sequencer.  The
// sequencer decides which counter_core control is active on each edge;
// ovf registers the core's wrap/saturation event for one cycle.
module run_counter
   import run_counter_pkg::*;
#(
   parameter int     WIDTH    = WIDTH_DEF,
   parameter longint TERMINAL = TERMINAL_DEF
) (
   input  logic             clock,
   input  logic             clr_n,
   input  logic             en,
   input  logic             sync_clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             up_dn,
   input  logic             sat,
   input  logic             start,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             tc,
   output logic             ovf
);

   if (WIDTH < 2 || WIDTH > 32 || !terminal_ok(WIDTH, TERMINAL)) begin : g_param_err
      $error("run_counter: WIDTH must be 2..32 and TERMINAL 1..2**WIDTH");
   end

   // Last count value of a run; TERMINAL==2**WIDTH gives all-ones, so the
   // final step wraps through the core and raises ovf with done.
   localparam logic [WIDTH-1:0] LAST = WIDTH'(TERMINAL - 1);

   logic [1:0] state;
   logic [1:0] nstate;
   logic       c_clr;
   logic       c_load;
   logic       c_inc;
   logic       c_dec;
   logic       c_sat;
   logic       evt;

   counter_core #(.WIDTH(WIDTH)) u_core (
      .clock    (clock),
      .clr_n    (clr_n),
      .clr      (c_clr),
      .load     (c_load),
      .load_val (load_val),
      .inc      (c_inc),
      .dec      (c_dec),
      .sat      (c_sat),
      .up_dn    (up_dn),
      .count    (count),
      .tc       (tc),
      .evt      (evt)
   );

   // Sequencer next state and per-edge counter controls
   always_comb begin
      nstate = state;
      c_clr  = 1'b0;
      c_load = 1'b0;
      c_inc  = 1'b0;
      c_dec  = 1'b0;
      c_sat  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (sync_clr) begin
               c_clr = 1'b1;
            end else if (start) begin
               c_clr  = 1'b1;
               nstate = ST_RUN;
            end else if (load) begin
               c_load = 1'b1;
            end else if (en) begin
               c_sat = sat;
               c_inc = up_dn;
               c_dec = !up_dn;
            end
         end
         ST_RUN: begin
            if (sync_clr) begin
               c_clr  = 1'b1;
               nstate = ST_IDLE;
            end else if (en) begin
               c_inc = 1'b1;
               if (count == LAST) nstate = ST_DONE;
            end
         end
         ST_DONE: begin
            c_clr  = sync_clr;
            nstate = ST_IDLE;
         end
         default: nstate = ST_IDLE;
      endcase
   end

   // State and overflow registers
   always_ff @(posedge clock or negedge clr_n) begin
      if (!clr_n) begin
         state <= ST_IDLE;
         ovf   <= 1'b0;
      end else begin
         state <= nstate;
         ovf   <= evt;
      end
   end

   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_run_counter.sv
// Directed bench for run_counter: two instances (TERMINAL 32 and 64, WIDTH 6)
// share stimulus and are compared every cycle against a behavioural model,
// with literal expectations at the interesting points.
module tb_run_counter;

   localparam int W = 6;

   logic         clock = 1'b0;
   logic         clr_n = 1'b0;
   logic         en = 1'b0, sync_clr = 1'b0, load = 1'b0;
   logic         up_dn = 1'b1, sat = 1'b0, start = 1'b0;
   logic [W-1:0] load_val = '0;

   logic [W-1:0] count_a, count_b;
   logic         busy_a, done_a, tc_a, ovf_a;
   logic         busy_b, done_b, tc_b, ovf_b;

   int total = 0;
   int bad   = 0;
   int nb;
   int g;

   always #5 clock = ~clock;

   run_counter #(.WIDTH(W), .TERMINAL(32)) dut_a (
      .clock(clock), .clr_n(clr_n), .en(en), .sync_clr(sync_clr), .load(load),
      .load_val(load_val), .up_dn(up_dn), .sat(sat), .start(start),
      .count(count_a), .busy(busy_a), .done(done_a), .tc(tc_a), .ovf(ovf_a));

   run_counter #(.WIDTH(W), .TERMINAL(64)) dut_b (
      .clock(clock), .clr_n(clr_n), .en(en), .sync_clr(sync_clr), .load(load),
      .load_val(load_val), .up_dn(up_dn), .sat(sat), .start(start),
      .count(count_b), .busy(busy_b), .done(done_b), .tc(tc_b), .ovf(ovf_b));

   // Model: plain integer count, run tracked by number of enabled steps taken
   typedef struct packed {
      int cnt;
      bit run;
      bit dn;
      bit ov;
      int steps;
   } mst_t;

   mst_t ma, mb;

   function automatic mst_t mstep(input mst_t s, input int term);
      mst_t n;
      int top;
      n    = s;
      top  = (1 << W) - 1;
      n.dn = 1'b0;
      n.ov = 1'b0;
      if (s.run) begin
         if (sync_clr) begin
            n.cnt = 0;
            n.run = 1'b0;
         end else if (en) begin
            n.steps = s.steps + 1;
            n.cnt   = s.cnt + 1;
            if (n.cnt > top) begin
               n.cnt = 0;
               n.ov  = 1'b1;
            end
            if (n.steps == term) begin
               n.run = 1'b0;
               n.dn  = 1'b1;
            end
         end
      end else if (s.dn) begin
         if (sync_clr) n.cnt = 0;
      end else begin
         if (sync_clr) n.cnt = 0;
         else if (start) begin
            n.cnt   = 0;
            n.run   = 1'b1;
            n.steps = 0;
         end else if (load) n.cnt = int'(load_val);
         else if (en) begin
            if (up_dn) begin
               if (s.cnt == top) begin
                  n.ov  = 1'b1;
                  n.cnt = sat ? top : 0;
               end else n.cnt = s.cnt + 1;
            end else begin
               if (s.cnt == 0) begin
                  n.ov  = 1'b1;
                  n.cnt = sat ? 0 : top;
               end else n.cnt = s.cnt - 1;
            end
         end
      end
      return n;
   endfunction

   // Model state advances on the same edges as the DUTs
   always @(posedge clock or negedge clr_n) begin
      if (!clr_n) begin
         ma <= '0;
         mb <= '0;
      end else begin
         ma <= mstep(ma, 32);
         mb <= mstep(mb, 64);
      end
   end

   function automatic bit mtc(input int c);
      return up_dn ? (c == (1 << W) - 1) : (c == 0);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic cmp_model();
      chk("a.count", 32'(count_a), ma.cnt);
      chk("a.busy",  32'(busy_a),  32'(ma.run));
      chk("a.done",  32'(done_a),  32'(ma.dn));
      chk("a.ovf",   32'(ovf_a),   32'(ma.ov));
      chk("a.tc",    32'(tc_a),    32'(mtc(ma.cnt)));
      chk("b.count", 32'(count_b), mb.cnt);
      chk("b.busy",  32'(busy_b),  32'(mb.run));
      chk("b.done",  32'(done_b),  32'(mb.dn));
      chk("b.ovf",   32'(ovf_b),   32'(mb.ov));
      chk("b.tc",    32'(tc_b),    32'(mtc(mb.cnt)));
   endtask

   // One clock edge, then compare 3 time units later (inputs change after)
   task automatic tick();
      @(posedge clock);
      #3;
      cmp_model();
   endtask

   initial begin
      #2;
      chk("rst.count", 32'(count_a), 0);
      chk("rst.busy",  32'(busy_a), 0);
      chk("rst.done",  32'(done_a), 0);
      chk("rst.ovf",   32'(ovf_a), 0);
      #1 clr_n = 1'b1;

      // Up, wrap
      up_dn = 1'b1; sat = 1'b0; load = 1'b1; load_val = 6'd62;
      tick(); chk("up.load", 32'(count_a), 62);
      load = 1'b0; en = 1'b1;
      tick(); chk("up.63", 32'(count_a), 63); chk("up.63.ovf", 32'(ovf_a), 0);
      tick(); chk("up.wrap", 32'(count_a), 0); chk("up.wrap.ovf", 32'(ovf_a), 1);
      en = 1'b0;
      tick(); chk("up.ovf.clear", 32'(ovf_a), 0);

      // Up, saturate
      sat = 1'b1; load = 1'b1;
      tick();
      load = 1'b0; en = 1'b1;
      tick(); chk("sat.63", 32'(count_a), 63);
      tick(); chk("sat.hold", 32'(count_a), 63); chk("sat.ovf", 32'(ovf_a), 1);
      en = 1'b0;
      tick(); chk("sat.ovf.clear", 32'(ovf_a), 0);

      // Down, wrap
      up_dn = 1'b0; sat = 1'b0; load = 1'b1; load_val = 6'd1;
      tick();
      load = 1'b0; en = 1'b1;
      tick(); chk("dn.0", 32'(count_a), 0); chk("dn.tc", 32'(tc_a), 1);
      tick(); chk("dn.wrap", 32'(count_a), 63); chk("dn.ovf", 32'(ovf_a), 1);
      chk("dn.tc.off", 32'(tc_a), 0);
      en = 1'b0;
      tick();

      // Run with en held high, stray start mid-run
      up_dn = 1'b1; start = 1'b1;
      tick(); chk("run.busy0", 32'(busy_a), 1); chk("run.count0", 32'(count_a), 0);
      start = 1'b0; en = 1'b1; nb = 1; g = 0;
      while (busy_a && g < 100) begin
         start = (g == 10);
         tick();
         g++;
         if (busy_a) nb++;
      end
      start = 1'b0;
      chk("run.busy_len", nb, 32);
      chk("run.done", 32'(done_a), 1);
      chk("run.done.count", 32'(count_a), 32);
      tick(); chk("run.done.gone", 32'(done_a), 0); chk("run.hold", 32'(count_a), 32);
      en = 1'b0; sync_clr = 1'b1;
      tick();
      sync_clr = 1'b0;

      // Run with en toggling
      start = 1'b1;
      tick();
      start = 1'b0; nb = 1; g = 0;
      while (busy_a && g < 200) begin
         en = (g % 2 == 1);
         tick();
         g++;
         if (busy_a) nb++;
      end
      chk("tog.busy_len", nb, 64);
      chk("tog.done", 32'(done_a), 1);
      en = 1'b0; sync_clr = 1'b1;
      tick();
      sync_clr = 1'b0;

      // Abort at count 10
      start = 1'b1;
      tick();
      start = 1'b0; en = 1'b1; g = 0;
      while (count_a != 6'd10 && g < 50) begin
         tick();
         g++;
      end
      chk("abort.at10", 32'(count_a), 10);
      sync_clr = 1'b1;
      tick();
      chk("abort.count", 32'(count_a), 0); chk("abort.busy", 32'(busy_a), 0);
      chk("abort.done", 32'(done_a), 0);
      sync_clr = 1'b0; en = 1'b0;
      tick(); chk("abort.nodone", 32'(done_a), 0);

      // TERMINAL = 2**WIDTH: final step wraps
      start = 1'b1;
      tick();
      start = 1'b0; en = 1'b1; nb = 1; g = 0;
      while (busy_b && g < 200) begin
         tick();
         g++;
         if (busy_b) nb++;
      end
      chk("full.busy_len", nb, 64);
      chk("full.done", 32'(done_b), 1);
      chk("full.ovf", 32'(ovf_b), 1);
      chk("full.count", 32'(count_b), 0);
      en = 1'b0;
      tick(); chk("full.ovf.clear", 32'(ovf_b), 0);

      // Asynchronous reset in the middle of a run
      en = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      clr_n = 1'b0;
      #1;
      chk("arst.count", 32'(count_a), 0); chk("arst.busy", 32'(busy_a), 0);
      chk("arst.done",  32'(done_a), 0);  chk("arst.ovf",  32'(ovf_a), 0);
      chk("arst.b.count", 32'(count_b), 0); chk("arst.b.busy", 32'(busy_b), 0);
      #3 clr_n = 1'b1;
      en = 1'b0;
      tick(); chk("arst.after", 32'(busy_a), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
